// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end and the control decoder.
//   XLEN            address / instruction width
//   OPC_*           major opcodes (instr[6:0]) seen by the control decoder
//   fetch_entry_t   one buffered fetch result: instruction word plus its PC
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch instruction buffer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_entry  write an entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push, a same-cycle pop is moot
//   head_entry      entry at the head (valid when !empty)
//   empty           no entries held
//   count           number of entries held
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_entry,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t        mem_q [DEPTH];
    fetch_entry_t        mem_d [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Pointer increment that also works for depths that are not a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = push && (count_q < CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end. Holds the PC, issues in-order word requests to
// instruction memory, buffers returned words and presents {instr, pc, opcode}
// to the control decoder. Redirects from branch/jump resolution flush the
// buffer and mark every in-flight request as stale so its response is dropped.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a source holding valid keeps its payload stable until it transfers.
// rsp_valid is a pulse with no backpressure, returned in request order.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request to memory (word aligned)
//   rsp_valid/rsp_data             in-order response from memory
//   instr_valid/instr_ready        downstream handshake
//   instr/instr_pc/opcode          buffered word at the head, its PC, instr[6:0]
//   redirect_valid/redirect_pc     single-cycle redirect, redirect_pc[1:0] ignored
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    // PC of the next response that will be kept; advances only on pushes, so
    // dropped stale responses never disturb it.
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic [XLEN-1:0] redirect_target;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    assign redirect_target = redirect_pc & ~XLEN'(3);
    // Stale requests still occupy a credit until their response returns.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req_valid = !reset && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
    assign req_addr  = pc_q;
    assign req_fire  = req_valid && req_ready;

    assign fifo_push        = rsp_valid && (stale_q == '0) && !redirect_valid;
    assign fifo_pop         = instr_valid && instr_ready;
    assign push_entry.instr = rsp_data;
    assign push_entry.pc    = tag_pc_q;

    always_comb begin
        pc_d          = pc_q;
        tag_pc_d      = tag_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_valid);
        stale_d       = stale_q;
        if (redirect_valid) begin
            pc_d     = redirect_target;
            tag_pc_d = redirect_target;
            // Everything still in flight after this cycle is wrong-path.
            stale_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (fifo_push) begin
                tag_pc_d = tag_pc_q + XLEN'(4);
            end
            if (rsp_valid && (stale_q != '0)) begin
                stale_d = stale_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            tag_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            tag_pc_q      <= tag_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .head_entry (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Outputs read as zero whenever the buffer is empty.
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign opcode      = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory model ----------------
    // Entries: {due_cycle, addr}. Responses return in order, no earlier than due.
    logic [63:0] mem_q[$];
    int          mem_lat_max = 1;

    initial begin
        logic [63:0] e;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_q.delete();
                rsp_valid = 1'b0;
            end else if (mem_q.size() > 0 && int'(mem_q[0][63:32]) <= cyc) begin
                e         = mem_q.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = mem_word(e[31:0]);
            end else begin
                rsp_valid = 1'b0;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    // The delivered stream must be the consecutive words starting at the last
    // reset/redirect target; each accepted request pushes its expected word.
    logic [63:0] exp_q[$];           // {instr, pc}
    logic [31:0] model_pc;
    int          outst_m, stale_m, buf_m;

    always @(negedge clk) begin
        logic        fire, pop;
        logic [63:0] e;
        if (reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
            outst_m  = 0;
            stale_m  = 0;
            buf_m    = 0;
        end else begin
            fire = req_valid && req_ready;
            pop  = instr_valid && instr_ready;
            check("req_valid", {31'b0, req_valid},
                  {31'b0, (!redirect_valid && (outst_m + buf_m < DEPTH))});
            check("instr_valid", {31'b0, instr_valid}, {31'b0, (buf_m > 0)});
            if (req_valid) check("req_addr", req_addr, model_pc);
            if (pop) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pc 0x%08h expected no word (t=%0t)", instr_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", instr, e[63:32]);
                    check("instr_pc", instr_pc, e[31:0]);
                    check("opcode", {25'b0, opcode}, {25'b0, e[38:32]});
                end
            end
            if (fire) mem_q.push_back({32'(cyc + $urandom_range(1, mem_lat_max)), req_addr});
            if (redirect_valid) begin
                outst_m  = outst_m + int'(fire) - int'(rsp_valid);
                stale_m  = outst_m;
                buf_m    = 0;
                exp_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (rsp_valid) begin
                    outst_m--;
                    if (stale_m > 0) stale_m--;
                    else buf_m++;
                end
                if (fire) begin
                    outst_m++;
                    exp_q.push_back({mem_word(model_pc), model_pc});
                    model_pc = model_pc + 32'd4;
                end
                if (pop) buf_m--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_valid"}, {31'b0, req_valid}, 32'd0);
        check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_opcode"}, {25'b0, opcode}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        reset          = 1'b1;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        check_outputs_zero("reset");
        step(2);
        reset = 1'b0;
        #1;
        check("first_req_valid", {31'b0, req_valid}, 32'd1);
        check("first_req_addr", req_addr, RESET_PC);

        // 1: streaming with 1-cycle memory
        req_ready   = 1'b1;
        instr_ready = 1'b1;
        mem_lat_max = 1;
        step(20);

        // 2: downstream stalled fills the buffer, then drains in order
        do_reset();
        instr_ready = 1'b0;
        step(10);
        check("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        check("stall_head_pc", instr_pc, 32'h100);
        check("stall_req_valid", {31'b0, req_valid}, 32'd0);
        instr_ready = 1'b1;
        step(1);
        check("drain_head_pc", instr_pc, 32'h104);
        check("resume_req_addr", req_addr, 32'h108);
        step(10);

        // 3: redirect with two requests in flight
        do_reset();
        mem_lat_max = 3;
        waited = 0;
        while (outst_m < 2 && waited < 20) begin
            step(1);
            waited++;
        end
        check("two_in_flight", outst_m, 32'd2);
        redirect(32'h200);
        step(0);
        @(negedge clk);
        check("redir_req_addr", req_addr, 32'h200);
        check("redir_flushed", {31'b0, instr_valid}, 32'd0);
        step(15);

        // 4: unaligned redirect target; redirect coincides with responses
        mem_lat_max = 1;
        step(3);
        redirect(32'h203);
        @(negedge clk);
        check("align_req_addr", req_addr, 32'h200);
        step(10);

        // 5: memory stall holds the address, redirect overrides it
        do_reset();
        step(1);
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("hold_req_addr", req_addr, 32'h104);
        end
        redirect(32'h300);
        check("stall_redir_addr", req_addr, 32'h300);
        req_ready = 1'b1;
        step(10);

        // 6: PC wrap, then reset with a full buffer
        redirect(32'hFFFF_FFFC);
        check("wrap_start", req_addr, 32'hFFFF_FFFC);
        step(1);
        check("wrap_to_zero", req_addr, 32'h0);
        instr_ready = 1'b0;
        step(8);
        check("full_before_reset", {31'b0, instr_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        step(2);
        reset = 1'b0;
        #1;
        check("post_reset_req_addr", req_addr, RESET_PC);
        check("post_reset_req_valid", {31'b0, req_valid}, 32'd1);

        // random traffic
        mem_lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            req_ready   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            step(1);
        end
        redirect_valid = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b1;
        step(10);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
